alu_seq_exec: RTL

//  Multi-cycle ALU execution unit. Consumes the 5-bit ALU operation code produced by
//  the ALU decoder, plus two XLEN operands, over a valid/ready handshake.

---
 rtl/alu_seq_exec_if.sv | 27 ++
 rtl/alu_seq_exec.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec_if.sv
// Handshake bus between operand select, the multi-cycle ALU and writeback.
interface alu_seq_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    // Producer/consumer side: drives operands, accepts results
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // Execution unit side
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, shifts iterate one bit per cycle.
module alu_seq_exec #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_exec_if.slave bus
);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLL    = 5'b00101;
    localparam logic [4:0] OP_SRL    = 5'b00110;
    localparam logic [4:0] OP_SLT    = 5'b00111;
    localparam logic [4:0] OP_SRA    = 5'b01110;
    localparam logic [4:0] OP_SLTU   = 5'b01111;
    localparam logic [4:0] OP_SLL_12 = 5'b10000;

    localparam int unsigned SLL12_COUNT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_t;

    state_t              state, state_d;
    shift_kind_t         kind, kind_d;
    logic [SHAMT_W-1:0]  count, count_d;
    logic [XLEN-1:0]     work, work_d;
    logic [XLEN-1:0]     result, result_d;
    logic                zero, zero_d;
    logic                illegal, illegal_d;
    logic                in_ready, out_valid;
    logic [XLEN-1:0]     work_step;

    // One-bit step of the shift working register
    always_comb begin
        work_step = work;
        case (kind)
            SK_SLL:  work_step = {work[XLEN-2:0], 1'b0};
            SK_SRL:  work_step = {1'b0, work[XLEN-1:1]};
            SK_SRA:  work_step = {work[XLEN-1], work[XLEN-1:1]};
            default: work_step = work;
        endcase
    end

    // Next-state, operation decode and result load
    always_comb begin
        logic [XLEN-1:0]    alu_val;
        logic               alu_ill;
        logic               is_shift;
        logic [XLEN-1:0]    src;
        logic [SHAMT_W-1:0] amt;
        shift_kind_t        sk;

        state_d   = state;
        kind_d    = kind;
        count_d   = count;
        work_d    = work;
        result_d  = result;
        zero_d    = zero;
        illegal_d = illegal;
        alu_val   = '0;
        alu_ill   = 1'b0;
        is_shift  = 1'b0;
        src       = bus.a;
        amt       = bus.b[SHAMT_W-1:0];
        sk        = SK_SLL;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    case (bus.op)
                        OP_ADD:    alu_val = bus.a + bus.b;
                        OP_SUB:    alu_val = bus.a - bus.b;
                        OP_AND:    alu_val = bus.a & bus.b;
                        OP_OR:     alu_val = bus.a | bus.b;
                        OP_XOR:    alu_val = bus.a ^ bus.b;
                        OP_SLT:    alu_val = XLEN'($signed(bus.a) < $signed(bus.b));
                        OP_SLTU:   alu_val = XLEN'(bus.a < bus.b);
                        OP_SLL:    is_shift = 1'b1;
                        OP_SRL: begin
                            is_shift = 1'b1;
                            sk       = SK_SRL;
                        end
                        OP_SRA: begin
                            is_shift = 1'b1;
                            sk       = SK_SRA;
                        end
                        OP_SLL_12: begin
                            is_shift = 1'b1;
                            src      = bus.b;
                            amt      = SHAMT_W'(SLL12_COUNT);
                        end
                        default:   alu_ill = 1'b1;
                    endcase

                    if (is_shift && (amt != '0)) begin
                        kind_d  = sk;
                        work_d  = src;
                        count_d = amt;
                        state_d = SHIFT;
                    end else begin
                        // Zero-count shifts pass the source straight through
                        result_d  = is_shift ? src : alu_val;
                        zero_d    = is_shift ? (src == '0) : (alu_val == '0);
                        illegal_d = alu_ill;
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d  = work_step;
                count_d = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    result_d  = work_step;
                    zero_d    = (work_step == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; handshake flags registered from next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            kind      <= SK_SLL;
            count     <= '0;
            work      <= '0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            kind      <= kind_d;
            count     <= count_d;
            work      <= work_d;
            result    <= result_d;
            zero      <= zero_d;
            illegal   <= illegal_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.zero      = zero;
    assign bus.illegal   = illegal;

endmodule
